lbist_tpg: RTL and testbench

LBIST test pattern generator and run sequencer. It sits directly upstream of the CUT and the ORA.
- An LFSR produces pseudo-random patterns on CUT_IP.
- A window counter groups patterns into signature windows.
- At the end of each window it presents the fault-free signature index on SIG_ADD, which drives the ORA's IP_SIG_ADD input.
- Run status (BUSY/DONE) goes to the LBIST top-level control.

---
 rtl/lbist_tpg.sv | 135 +++++++++++++
 tb/tb_lbist_tpg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_tpg.sv
// lbist_tpg: LBIST test pattern generator and run sequencer.
// A Fibonacci LFSR drives CUT_IP. Patterns are grouped into signature windows of
// PAT_PER_SIG patterns, and NUM_SIGS windows make up one run. SIG_STROBE marks the
// last pattern of each window, while SIG_ADD carries that window's index to the ORA.
// Optional build macro LBIST_TPG_LOCKUP_GUARD_EN: when defined, an all-zero SEED
// is loaded as all-ones so that the LFSR cannot lock up.
module lbist_tpg #(
  parameter int unsigned         IP_WIDTH        = 4,
  parameter int unsigned         IP_SIG_ADD_BITS = 4,
  parameter logic [0:IP_WIDTH-1] TAPS            = 4'b1100,
  parameter int unsigned         PAT_PER_SIG     = 4,
  parameter int unsigned         NUM_SIGS        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       hold,
  input  logic [0:IP_WIDTH-1]        SEED,
  output logic [0:IP_WIDTH-1]        CUT_IP,
  output logic                       TP_VALID,
  output logic [0:IP_SIG_ADD_BITS-1] SIG_ADD,
  output logic                       SIG_STROBE,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int unsigned PCW = (PAT_PER_SIG > 1) ? $clog2(PAT_PER_SIG) : 1;
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PAT_PER_SIG - 1);
  localparam logic [0:IP_SIG_ADD_BITS-1] WIN_LAST = IP_SIG_ADD_BITS'(NUM_SIGS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                     state_q;
  logic [0:IP_WIDTH-1]        lfsr_q;
  logic [PCW-1:0]             pcnt_q;

  logic [0:IP_WIDTH-1]        lfsr_next;
  logic [0:IP_WIDTH-1]        lfsr_adv;
  logic [0:IP_WIDTH-1]        seed_load;
  logic [PCW-1:0]             pcnt_adv;
  logic [0:IP_SIG_ADD_BITS-1] widx_adv;
  logic                       last_pat;
  logic                       run_end;

  // LFSR step (index 0 is the MSB, shift towards it) and the seed actually loaded
  always_comb begin
    lfsr_next = {lfsr_q[1:IP_WIDTH-1], ^(lfsr_q & TAPS)};
    seed_load = SEED;
`ifdef LBIST_TPG_LOCKUP_GUARD_EN
    if (SEED == '0) begin
      seed_load = '1;
    end
`endif
  end

  // Advance only when the pattern on CUT_IP was actually presented (TP_VALID high);
  // a held cycle leaves the pending pattern in place.
  always_comb begin
    last_pat = (pcnt_q == PCNT_LAST);
    run_end  = TP_VALID && last_pat && (SIG_ADD == WIN_LAST);
    lfsr_adv = lfsr_q;
    pcnt_adv = pcnt_q;
    widx_adv = SIG_ADD;
    if (TP_VALID) begin
      lfsr_adv = lfsr_next;
      if (last_pat) begin
        pcnt_adv = '0;
        widx_adv = SIG_ADD + 1'b1;
      end else begin
        pcnt_adv = pcnt_q + 1'b1;
      end
    end
  end

  // Run sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lfsr_q     <= '0;
      pcnt_q     <= '0;
      CUT_IP     <= '0;
      TP_VALID   <= 1'b0;
      SIG_ADD    <= '0;
      SIG_STROBE <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else if (abort) begin
      // The LFSR keeps its value; only the visible outputs and the counters are cleared.
      state_q    <= StIdle;
      pcnt_q     <= '0;
      CUT_IP     <= '0;
      TP_VALID   <= 1'b0;
      SIG_ADD    <= '0;
      SIG_STROBE <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            lfsr_q     <= seed_load;
            CUT_IP     <= seed_load;
            pcnt_q     <= '0;
            SIG_ADD    <= '0;
            TP_VALID   <= 1'b1;
            SIG_STROBE <= (PAT_PER_SIG == 1);
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
          end
        end
        StRun: begin
          if (run_end) begin
            // The final increment is suppressed, so SIG_ADD and CUT_IP hold their last values.
            state_q    <= StDone;
            TP_VALID   <= 1'b0;
            SIG_STROBE <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
          end else begin
            lfsr_q     <= lfsr_adv;
            CUT_IP     <= lfsr_adv;
            pcnt_q     <= pcnt_adv;
            SIG_ADD    <= widx_adv;
            TP_VALID   <= !hold;
            SIG_STROBE <= !hold && (pcnt_adv == PCNT_LAST);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lbist_tpg.sv
// tb_lbist_tpg: randomized and directed bench for lbist_tpg.
// The model tracks the run as "number of patterns consumed so far" and derives
// the window index and strobe from that count arithmetically.
module tb_lbist_tpg;

  localparam int PPS   = 4;
  localparam int NS    = 16;
  localparam int TOTAL = PPS * NS;

  logic       clk, rst;
  logic       start, abort, hold;
  logic [3:0] seed;
  logic [3:0] cut_ip, sig_add;
  logic       tp_valid, sig_strobe, busy, done;

  // second instance: one window of 15 patterns (full LFSR period)
  logic       start_b;
  logic       abort_b, hold_b;
  logic [3:0] seed_b;
  logic [3:0] cut_ip_b, sig_add_b;
  logic       tp_valid_b, sig_strobe_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  lbist_tpg dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold), .SEED(seed),
    .CUT_IP(cut_ip), .TP_VALID(tp_valid), .SIG_ADD(sig_add), .SIG_STROBE(sig_strobe),
    .BUSY(busy), .DONE(done)
  );

  lbist_tpg #(.PAT_PER_SIG(15), .NUM_SIGS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .hold(hold_b), .SEED(seed_b),
    .CUT_IP(cut_ip_b), .TP_VALID(tp_valid_b), .SIG_ADD(sig_add_b), .SIG_STROBE(sig_strobe_b),
    .BUSY(busy_b), .DONE(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // polynomial x^4+x^3+1: new LSB = b3 ^ b2 of the MSB-first pattern
  function automatic logic [3:0] step(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

  function automatic logic [3:0] load(input logic [3:0] s);
`ifdef LBIST_TPG_LOCKUP_GUARD_EN
    return (s == 4'h0) ? 4'hf : s;
`else
    return s;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  int         m_st;   // 0 idle, 1 run, 2 done
  int         m_n;    // patterns consumed in this run
  logic       m_v;    // current pattern is presented (not held)
  logic [3:0] m_pat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_n <= 0; m_v <= 1'b0; m_pat <= 4'h0;
    end else if (abort) begin
      m_st <= 0; m_n <= 0; m_v <= 1'b0;
    end else if (m_st != 1) begin
      if (start) begin
        m_st <= 1; m_n <= 0; m_v <= 1'b1; m_pat <= load(seed);
      end
    end else begin
      if (m_v && m_n == TOTAL - 1) begin
        m_st <= 2; m_v <= 1'b0;
      end else begin
        if (m_v) begin
          m_n   <= m_n + 1;
          m_pat <= step(m_pat);
        end
        m_v <= !hold;
      end
    end
  end

  logic [3:0] e_cut, e_sig;
  logic       e_v, e_st, e_busy, e_done;

  always_comb begin
    e_cut = 4'h0; e_sig = 4'h0; e_v = 1'b0; e_st = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_st == 1) begin
      e_cut  = m_pat;
      e_v    = m_v;
      e_sig  = 4'(m_n / PPS);
      e_st   = m_v && ((m_n % PPS) == PPS - 1);
      e_busy = 1'b1;
    end else if (m_st == 2) begin
      e_cut  = m_pat;
      e_sig  = 4'(NS - 1);
      e_done = 1'b1;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("cut_ip",     32'(cut_ip),     32'(e_cut));
      check("tp_valid",   32'(tp_valid),   32'(e_v));
      check("sig_add",    32'(sig_add),    32'(e_sig));
      check("sig_strobe", 32'(sig_strobe), 32'(e_st));
      check("busy",       32'(busy),       32'(e_busy));
      check("done",       32'(done),       32'(e_done));
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] q[$];
  logic [3:0] exp1 [8];
  int         nvalid, nstrobe, nnonzero;
  logic [15:0] seen;
  logic [3:0] last_b, s2;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [3:0] s);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_cut"},  32'(cut_ip),     32'h0);
    check({tag, "_val"},  32'(tp_valid),   32'h0);
    check({tag, "_sig"},  32'(sig_add),    32'h0);
    check({tag, "_str"},  32'(sig_strobe), 32'h0);
    check({tag, "_busy"}, 32'(busy),       32'h0);
    check({tag, "_done"}, 32'(done),       32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; seed = 4'h0;
    start_b = 1'b0; abort_b = 1'b0; hold_b = 1'b0; seed_b = 4'h1;
    exp1[0] = 4'b0001; exp1[1] = 4'b0010; exp1[2] = 4'b0100; exp1[3] = 4'b1001;
    exp1[4] = 4'b0011; exp1[5] = 4'b0110; exp1[6] = 4'b1101; exp1[7] = 4'b1010;
    tick();
    all_zero("reset");
    tick();
    rst = 1'b0;
    tick();
    all_zero("idle");

    // Full-period window on the second instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    seen = '0; nvalid = 0; last_b = 4'h0;
    for (int c = 1; c <= 16; c++) begin
      if (c <= 15 && tp_valid_b) begin
        nvalid++;
        seen[cut_ip_b] = 1'b1;
        last_b = cut_ip_b;
      end
      if (c == 15) check("b_strobe", 32'(sig_strobe_b), 32'h1);
      if (c == 16) check("b_done", 32'(done_b), 32'h1);
      tick();
    end
    check("b_count", 32'(nvalid), 32'd15);
    check("b_distinct", 32'($countones(seen)), 32'd15);
    check("b_nozero", 32'(seen[0]), 32'h0);
    check("b_last", 32'(last_b), 32'b1000);

    // Test 1: SEED=0001, plain run
    start_run(4'b0001);
    q.delete(); nstrobe = 0;
    for (int c = 1; c <= 66; c++) begin
      if (tp_valid) q.push_back(cut_ip);
      if (sig_strobe) begin
        check("t1_strobe_pos", 32'(c), 32'(4 * (nstrobe + 1)));
        check("t1_strobe_idx", 32'(sig_add), 32'(nstrobe));
        nstrobe++;
      end
      if (c == 65) begin
        check("t1_done", 32'(done), 32'h1);
        check("t1_sig_final", 32'(sig_add), 32'd15);
      end
      tick();
    end
    check("t1_valid_count", 32'(q.size()), 32'd64);
    check("t1_strobe_count", 32'(nstrobe), 32'd16);
    for (int i = 0; i < 8; i++) check("t1_pattern", 32'(q[i]), 32'(exp1[i]));

    // Test 6: restart from DONE, then async reset inside window 5
    start_run(4'b0001);
    check("t6_done_drop", 32'(done), 32'h0);
    check("t6_busy", 32'(busy), 32'h1);
    check("t6_first", 32'(cut_ip), 32'b0001);
    for (int c = 1; c < 22; c++) tick();
    check("t6_window", 32'(sig_add), 32'd5);
    #2 rst = 1'b1;
    #1 all_zero("t6_async");
    tick();
    check("t6_nostrobe", 32'(sig_strobe), 32'h0);
    rst = 1'b0;
    tick();

    // Test 3: hold for three cycles after the first pattern
    start_run(4'b0001);
    nvalid = 0;
    for (int c = 1; c <= 70; c++) begin
      if (tp_valid) nvalid++;
      if (c == 3) begin
        check("t3_held_valid", 32'(tp_valid), 32'h0);
        check("t3_held_cut", 32'(cut_ip), 32'b0010);
        check("t3_held_busy", 32'(busy), 32'h1);
      end
      if (c == 5) check("t3_resume1", 32'(cut_ip), 32'b0010);
      if (c == 6) check("t3_resume2", 32'(cut_ip), 32'b0100);
      hold = (c >= 1 && c <= 3);
      tick();
    end
    hold = 1'b0;
    check("t3_valid_count", 32'(nvalid), 32'd64);

    // Test 4: abort together with start at pattern 10
    start_run(4'($urandom_range(1, 15)));
    for (int c = 1; c < 10; c++) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    all_zero("t4_abort");
    tick(); tick();
    s2 = 4'($urandom_range(1, 15));
    start_run(s2);
    check("t4_reload", 32'(cut_ip), 32'(s2));
    for (int c = 1; c <= 66; c++) tick();

    // Test 5: all-zero seed
    start_run(4'b0000);
    nvalid = 0; nnonzero = 0;
    for (int c = 1; c <= 66; c++) begin
`ifdef LBIST_TPG_LOCKUP_GUARD_EN
      if (c == 1) check("t5_p1", 32'(cut_ip), 32'b1111);
      if (c == 2) check("t5_p2", 32'(cut_ip), 32'b1110);
      if (c == 3) check("t5_p3", 32'(cut_ip), 32'b1100);
`endif
      if (tp_valid) begin
        nvalid++;
        if (cut_ip != 4'h0) nnonzero++;
      end
      tick();
    end
    check("t5_valid_count", 32'(nvalid), 32'd64);
`ifndef LBIST_TPG_LOCKUP_GUARD_EN
    check("t5_all_zero", 32'(nnonzero), 32'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      hold  = ($urandom_range(0, 4) == 0);
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 149) == 0);
      seed  = 4'($urandom_range(0, 15));
      tick();
    end
    hold = 1'b0; start = 1'b0; abort = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
